muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; every register updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: E-stage mult/div issue.
REQ-004 SHALL have port mul0_div1_sel, input, 1 bit: 0 = multiply, 1 = divide.
REQ-005 SHALL have port signed_op, input, 1 bit: 1 = two's-complement operands, 0 = unsigned operands.
REQ-006 SHALL have port in_a, input, 32 bits: multiplicand or dividend.
REQ-007 SHALL have port in_b, input, 32 bits: multiplier or divisor.
REQ-008 SHALL have port hilo_rd, input, 1 bit: E-stage mfhi/mflo request.
REQ-009 SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 SHALL have port stall_req, output, 1 bit: request to hazard unit to freeze F/D and flush E.
REQ-011 SHALL have port hi, output, 32 bits: HI register.
REQ-012 SHALL have port lo, output, 32 bits: LO register.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO are written.

Function
REQ-014 SHALL implement states IDLE, RUN and FIX.
REQ-015 SHALL, in IDLE with start=1, latch the operands in magnitude form (absolute values when signed_op=1), latch the operation and sign flags, clear the iteration counter, and enter RUN.
REQ-016 SHALL, in RUN, perform one radix-2 step per cycle: shift-add for multiply, restoring subtract for divide.
REQ-017 SHALL use a 6-bit iteration counter and leave RUN after exactly 32 steps, for FIX.
REQ-018 SHALL, in FIX: apply sign correction, write HI/LO, pulse done, and return to IDLE.
- Multiply: negate the 64-bit product if the operand signs differ.
- Divide: negate the quotient if the operand signs differ; give the remainder the sign of the dividend.
REQ-019 SHALL have latency as follows: start sampled at edge t gives HI/LO updated and done=1 after edge t+33; busy=1 from edge t through edge t+33.
REQ-020 SHALL drive busy=1 in RUN and FIX only.
REQ-021 SHALL assign stall_req = busy & (hilo_rd | start), combinationally.
REQ-022 SHALL ignore start while busy=1; upstream holds the instruction under stall.
REQ-023 SHALL, for multiply, place product[63:32] in HI and product[31:0] in LO.
REQ-024 SHALL, for divide, place the remainder in HI and the quotient in LO.
REQ-025 SHALL, for divide by zero, produce no exception: LO = 0xFFFFFFFF and HI = |dividend|, with the REQ-018 sign rules applied.
REQ-026 SHALL leave hi/lo unchanged outside the FIX cycle, so reads of a stale value are valid while idle.
REQ-027 SHALL treat the signed overflow case (0x80000000 / -1) per the same rules: LO = 0x80000000, HI = 0.

Reset
REQ-028 SHALL, with rst=1 at any edge including mid-RUN, enter IDLE with hi=0, lo=0, busy=0, done=0 and counter=0, and discard any in-flight operation.

Configuration
REQ-029 SHALL use macro MULDIV_FAST_MUL_EN.
- Defined: multiply uses a single-cycle combinational 32x32 product; start in IDLE writes HI/LO at the next edge with done=1; busy and stall never assert for multiply.
- Undefined: multiply is iterative per REQ-016 to REQ-019.
- Divide is iterative in both builds.

Structure
REQ-030 SHALL place the state encoding (IDLE/RUN/FIX), the width constant 32 and the iteration count 32 in shared package mips_pkg.
REQ-031 SHALL place one radix-2 step (shift-add / restoring subtract on a 64-bit partial register) in sub-module muldiv_step; the sequencer owns the FSM, counter, sign fix and HI/LO.

Verification
REQ-032 SHALL cover: unsigned mult 7*6 -> after 33 cycles done=1, hi=0x00000000, lo=0x0000002A.
REQ-033 SHALL cover: unsigned mult 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; signed mult of the same operands -> hi=0, lo=1.
REQ-034 SHALL cover: signed div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 100/0 unsigned -> lo=0xFFFFFFFF, hi=0x00000064.
REQ-035 SHALL cover: hilo_rd=1 held from cycle 5 after start -> stall_req=1 until busy falls, hi/lo correct on the first unstalled cycle.
REQ-036 SHALL cover: rst=1 at RUN step 10 -> next cycle busy=0, hi=lo=0; a new start then completes normally.
REQ-037 SHALL cover: back-to-back start held through busy -> second op starts the cycle after the first done, only once.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants, FSM encoding and sign helpers for the iterative multiply/divide sequencer.
package mips_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned PART_W   = 2 * XLEN;
    localparam int unsigned ITER_CNT = 32;
    localparam int unsigned CNT_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    typedef struct packed {
        logic div;
        logic neg_a;
        logic neg_b;
    } op_flags_t;

    function automatic logic [XLEN-1:0] neg_if(input logic en, input logic [XLEN-1:0] x);
        return en ? (~x + XLEN'(1)) : x;
    endfunction

    function automatic logic [PART_W-1:0] neg_if_wide(input logic en, input logic [PART_W-1:0] x);
        return en ? (~x + PART_W'(1)) : x;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between the E stage and the multiply/divide sequencer.
interface muldiv_sequencer_if;
    import mips_pkg::*;

    logic            start;
    logic            mul0_div1_sel;
    logic            signed_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            hilo_rd;
    logic            busy;
    logic            stall_req;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            done;

    modport master (
        output start, mul0_div1_sel, signed_op, in_a, in_b, hilo_rd,
        input  busy, stall_req, hi, lo, done
    );

    modport slave (
        input  start, mul0_div1_sel, signed_op, in_a, in_b, hilo_rd,
        output busy, stall_req, hi, lo, done
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 step on the 64-bit partial register: shift-add multiply or restoring divide.
module muldiv_step
    import mips_pkg::*;
(
    input  logic              div_i,
    input  logic [PART_W-1:0] part_i,
    input  logic [XLEN-1:0]   operand_i,
    output logic [PART_W-1:0] part_c
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] rem_trial;
    logic [XLEN:0] rem_diff;
    logic          rem_ge;

    // Multiply: low half holds remaining multiplier bits, product shifts in from the top.
    // Divide: {remainder, dividend/quotient} shifts left; a clear borrow bit means subtract fits.
    always_comb begin
        add_sum   = {1'b0, part_i[PART_W-1:XLEN]} + (part_i[0] ? {1'b0, operand_i} : (XLEN+1)'(0));
        rem_trial = part_i[PART_W-1:XLEN-1];
        rem_diff  = rem_trial - {1'b0, operand_i};
        rem_ge    = ~rem_diff[XLEN];
        if (div_i) begin
            part_c = rem_ge ? {rem_diff[XLEN-1:0], part_i[XLEN-2:0], 1'b1}
                            : {part_i[PART_W-2:0], 1'b0};
        end else begin
            part_c = {add_sum, part_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit (IDLE -> RUN x32 -> FIX).
// Build option MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
module muldiv_sequencer
    import mips_pkg::*;
(
    input logic               clk,
    input logic               rst,
    muldiv_sequencer_if.slave bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PART_W-1:0] part_q, part_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    op_flags_t         flags_q, flags_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [PART_W-1:0] step_c;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              sign_diff;
    logic              latch_iter;

    muldiv_step u_step (
        .div_i     (flags_q.div),
        .part_i    (part_q),
        .operand_i (opnd_q),
        .part_c    (step_c)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic [PART_W-1:0] fast_prod_c;
    assign fast_prod_c = {{XLEN{a_neg}}, bus.in_a} * {{XLEN{b_neg}}, bus.in_b};
`endif

    assign a_neg     = bus.signed_op & bus.in_a[XLEN-1];
    assign b_neg     = bus.signed_op & bus.in_b[XLEN-1];
    assign a_mag     = neg_if(a_neg, bus.in_a);
    assign b_mag     = neg_if(b_neg, bus.in_b);
    assign sign_diff = flags_q.neg_a ^ flags_q.neg_b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        opnd_d  = opnd_q;
        flags_d = flags_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

`ifdef MULDIV_FAST_MUL_EN
        latch_iter = bus.start & bus.mul0_div1_sel;
`else
        latch_iter = bus.start;
`endif

        unique case (state_q)
            ST_IDLE: begin
`ifdef MULDIV_FAST_MUL_EN
                if (bus.start && !bus.mul0_div1_sel) begin
                    {hi_d, lo_d} = fast_prod_c;
                    done_d       = 1'b1;
                end
`endif
                if (latch_iter) begin
                    part_d  = {XLEN'(0), a_mag};
                    opnd_d  = b_mag;
                    flags_d = '{div: bus.mul0_div1_sel, neg_a: a_neg, neg_b: b_neg};
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                part_d = step_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER_CNT - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // Quotient follows sign mismatch; remainder follows the dividend.
                if (flags_q.div) begin
                    hi_d = neg_if(flags_q.neg_a, part_q[PART_W-1:XLEN]);
                    lo_d = neg_if(sign_diff, part_q[XLEN-1:0]);
                end else begin
                    {hi_d, lo_d} = neg_if_wide(sign_diff, part_q);
                end
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            part_q  <= '0;
            opnd_q  <= '0;
            flags_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            opnd_q  <= opnd_d;
            flags_q <= flags_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.stall_req = busy_q & (bus.hilo_rd | bus.start);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases, random ops against a reference model.
module tb_muldiv_sequencer;

    logic clk = 1'b0;
    logic rst;
    muldiv_sequencer_if bus();

    muldiv_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int LAT = 33;

    // Reference: plain integer arithmetic; divide-by-zero gives all-ones magnitude quotient.
    function automatic logic [63:0] model(input logic div, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [31:0] q, r;
        sa = sgn ? longint'($signed(a)) : longint'({32'h0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'h0, b});
        if (!div) return 64'(sa * sb);
        if (b == 32'h0) begin
            q = (sgn && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
            return {a, q};
        end
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
    endfunction

    task automatic do_op(input logic div, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output int lat);
        bit seen;
        bus.start = 1'b1; bus.mul0_div1_sel = div; bus.signed_op = sgn;
        bus.in_a = a; bus.in_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1; seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (!seen) begin
                @(posedge clk); #1;
                if (bus.done) begin lat = i; seen = 1'b1; end
            end
        end
        hi = bus.hi; lo = bus.lo;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.mul0_div1_sel = 1'b0; bus.signed_op = 1'b0;
        bus.in_a = '0; bus.in_b = '0; bus.hilo_rd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        bus.hilo_rd = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        n_checks++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stall_req); end
        bus.hilo_rd = 1'b0;
    endtask

    task automatic test_directed();
        logic        t_div[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        t_sgn[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] t_a[6]   = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
        logic [31:0] t_b[6]   = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] t_hi[6]  = '{32'h0, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'h64, 32'h0};
        logic [31:0] t_lo[6]  = '{32'h2A, 32'h1, 32'h1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] hi, lo;
        int lat;
        for (int k = 0; k < 6; k++) begin
            do_op(t_div[k], t_sgn[k], t_a[k], t_b[k], hi, lo, lat);
            n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL directed%0d_latency got %0d want %0d", k, lat, LAT); end
            n_checks++; if (hi !== t_hi[k]) begin n_fail++; $display("FAIL directed%0d_hi got %h want %h", k, hi, t_hi[k]); end
            n_checks++; if (lo !== t_lo[k]) begin n_fail++; $display("FAIL directed%0d_lo got %h want %h", k, lo, t_lo[k]); end
            n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL directed%0d_busy_after got %b want 0", k, bus.busy); end
        end
    endtask

    task automatic test_random();
        logic div, sgn;
        logic [31:0] a, b, hi, lo;
        logic [63:0] exp;
        int lat;
        for (int k = 0; k < 24; k++) begin
            div = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = 32'($urandom);
            endcase
            exp = model(div, sgn, a, b);
            do_op(div, sgn, a, b, hi, lo, lat);
            n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", k, lat, LAT); end
            n_checks++; if (hi !== exp[63:32]) begin n_fail++; $display("FAIL rand%0d_hi div=%b sgn=%b a=%h b=%h got %h want %h", k, div, sgn, a, b, hi, exp[63:32]); end
            n_checks++; if (lo !== exp[31:0]) begin n_fail++; $display("FAIL rand%0d_lo div=%b sgn=%b a=%h b=%h got %h want %h", k, div, sgn, a, b, lo, exp[31:0]); end
            repeat (2) @(posedge clk);
            #1;
            n_checks++; if (bus.lo !== exp[31:0] || bus.done !== 1'b0) begin n_fail++; $display("FAIL rand%0d_idle_hold lo=%h done=%b want lo=%h done=0", k, bus.lo, bus.done, exp[31:0]); end
        end
    endtask

    task automatic test_hilo_stall();
        logic [31:0] a, b;
        logic [63:0] exp;
        logic exp_stall;
        a = 32'($urandom); b = 32'($urandom_range(1, 1000));
        exp = model(1'b1, 1'b0, a, b);
        bus.start = 1'b1; bus.mul0_div1_sel = 1'b1; bus.signed_op = 1'b0; bus.in_a = a; bus.in_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            @(posedge clk); #1;
            if (i >= 5) bus.hilo_rd = 1'b1;
            #1;
            exp_stall = (i >= 5) && (i < LAT);
            n_checks++; if (bus.stall_req !== exp_stall) begin n_fail++; $display("FAIL stall_cycle%0d got %b want %b", i, bus.stall_req, exp_stall); end
        end
        n_checks++; if (bus.hi !== exp[63:32]) begin n_fail++; $display("FAIL stall_release_hi got %h want %h", bus.hi, exp[63:32]); end
        n_checks++; if (bus.lo !== exp[31:0]) begin n_fail++; $display("FAIL stall_release_lo got %h want %h", bus.lo, exp[31:0]); end
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL stall_release_done got %b want 1", bus.done); end
        bus.hilo_rd = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] a, b, hi, lo;
        logic [63:0] exp;
        int lat;
        do_op(1'b0, 1'b0, 32'd7, 32'd6, hi, lo, lat);
        n_checks++; if (lo !== 32'h2A) begin n_fail++; $display("FAIL midrst_pre_lo got %h want 0000002a", lo); end
        bus.start = 1'b1; bus.mul0_div1_sel = 1'b0; bus.signed_op = 1'b1;
        bus.in_a = 32'($urandom); bus.in_b = 32'($urandom);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL midrst_hi got %h want 0", bus.hi); end
        n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL midrst_lo got %h want 0", bus.lo); end
        repeat (30) @(posedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.lo !== 32'h0) begin n_fail++; $display("FAIL midrst_discard busy=%b done=%b lo=%h want 0 0 0", bus.busy, bus.done, bus.lo); end
        a = 32'($urandom); b = 32'($urandom_range(1, 50));
        exp = model(1'b1, 1'b1, a, b);
        do_op(1'b1, 1'b1, a, b, hi, lo, lat);
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL midrst_after_latency got %0d want %0d", lat, LAT); end
        n_checks++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL midrst_after_result got %h want %h", {hi, lo}, exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, hi1, lo1, hi2, lo2;
        logic [63:0] exp1, exp2;
        int first_lat, second_lat, done_cnt;
        a1 = 32'($urandom); b1 = 32'($urandom);
        a2 = 32'($urandom); b2 = 32'($urandom_range(1, 9999));
        exp1 = model(1'b0, 1'b0, a1, b1);
        exp2 = model(1'b1, 1'b1, a2, b2);
        first_lat = -1; second_lat = -1; done_cnt = 0;
        hi1 = '0; lo1 = '0; hi2 = '0; lo2 = '0;
        bus.start = 1'b1; bus.mul0_div1_sel = 1'b0; bus.signed_op = 1'b0; bus.in_a = a1; bus.in_b = b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                done_cnt++;
                if (first_lat < 0) begin
                    first_lat = i; hi1 = bus.hi; lo1 = bus.lo;
                    bus.mul0_div1_sel = 1'b1; bus.signed_op = 1'b1; bus.in_a = a2; bus.in_b = b2;
                end else begin
                    second_lat = i; hi2 = bus.hi; lo2 = bus.lo;
                end
            end
            if (first_lat > 0 && i == first_lat + 1) begin
                n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_start busy got %b want 1", bus.busy); end
                bus.start = 1'b0;
            end
            if (i == 20) begin
                n_checks++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_held got %b want 1", bus.stall_req); end
            end
        end
        bus.start = 1'b0;
        n_checks++; if (first_lat != LAT) begin n_fail++; $display("FAIL b2b_first_latency got %0d want %0d", first_lat, LAT); end
        n_checks++; if ({hi1, lo1} !== exp1) begin n_fail++; $display("FAIL b2b_first_result got %h want %h", {hi1, lo1}, exp1); end
        n_checks++; if (second_lat != 2 * LAT + 1) begin n_fail++; $display("FAIL b2b_second_latency got %0d want %0d", second_lat, 2 * LAT + 1); end
        n_checks++; if ({hi2, lo2} !== exp2) begin n_fail++; $display("FAIL b2b_second_result got %h want %h", {hi2, lo2}, exp2); end
        n_checks++; if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after got busy=%b want 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hilo_stall();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
